crossbar_egress_port: RTL

- Egress end of the LATENTRED line-card crossbar, at the opposite end of the path from the ingress destination decoder.
- Collects packets from NUM_INPUTS crossbar sources whose TDEST carries {broadcast, dest switch port[5:0], crossbar bitmask[3:0]}.
- Accepts only sources whose bitmask bit PORT_INDEX is set, round-robin arbitrates between them on packet boundaries, and re-encodes TDEST to the 7-bit {broadcast, dest port} form.
- Output feeds one line card or uplink through a registered AXI-Stream stage.

---
 rtl/crossbar_egress_port.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/crossbar_egress_port.sv
// -----------------------------------------------------------------------------
// crossbar_egress_port
//
// Egress end of the LATENTRED line-card crossbar. Collects AXI-Stream packets
// from NUM_INPUTS crossbar sources. A source is eligible only when bit
// PORT_INDEX of its crossbar bitmask (s_tdest[3:0]) is set. Eligible sources
// are served round robin on packet boundaries. The 11-bit crossbar TDEST
// {broadcast, dest port[5:0], bitmask[3:0]} is re-encoded to the 7-bit
// {broadcast, dest port} form. The result is driven through one registered
// AXI-Stream output stage.
//
// Parameters:
//   NUM_INPUTS  number of crossbar source streams (2..8)
//   PORT_INDEX  crossbar bitmask bit served by this egress (0..3)
//   DATA_WIDTH  TDATA width; TKEEP is DATA_WIDTH/8
//   USER_WIDTH  TUSER width (VLAN ID), passed through unchanged
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_tvalid/s_tready   per-source handshake, one bit per source
//   s_tdata/s_tkeep     per-source payload, source i at slice i
//   s_tlast/s_tuser     per-source end of packet / VLAN
//   s_tdest             per-source 11-bit crossbar destination
//   m_t*                registered AXI-Stream output, m_tdest is 7 bits
//
// Optional build macro CROSSBAR_EGRESS_PERF_EN adds the outputs
// perf_pkt_count and perf_contention_count. Without the macro, these ports
// and their counters are absent.
// -----------------------------------------------------------------------------
module crossbar_egress_port #(
   parameter int NUM_INPUTS = 4,
   parameter int PORT_INDEX = 0,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 12
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_INPUTS-1:0]              s_tvalid,
   output logic [NUM_INPUTS-1:0]              s_tready,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   s_tdata,
   input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0] s_tkeep,
   input  logic [NUM_INPUTS-1:0]              s_tlast,
   input  logic [NUM_INPUTS*USER_WIDTH-1:0]   s_tuser,
   input  logic [NUM_INPUTS*11-1:0]           s_tdest,
   output logic                               m_tvalid,
   input  logic                               m_tready,
   output logic [DATA_WIDTH-1:0]              m_tdata,
   output logic [DATA_WIDTH/8-1:0]            m_tkeep,
   output logic                               m_tlast,
   output logic [USER_WIDTH-1:0]              m_tuser,
   output logic [6:0]                         m_tdest
`ifdef CROSSBAR_EGRESS_PERF_EN
   ,
   output logic [31:0]                        perf_pkt_count,
   output logic [31:0]                        perf_contention_count
`endif
);

   localparam int KEEP_WIDTH = DATA_WIDTH / 8;
   localparam int GW         = $clog2(NUM_INPUTS);
   localparam int TD_IN      = 11;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [GW-1:0]           grant_r;
   logic [GW-1:0]           last_grant_r;
   logic [GW-1:0]           arb_pick_s;
   logic                    arb_found_s;
   logic [NUM_INPUTS-1:0]   req_s;

   logic                    sel_valid_s;
   logic                    sel_last_s;
   logic [DATA_WIDTH-1:0]   sel_data_s;
   logic [KEEP_WIDTH-1:0]   sel_keep_s;
   logic [USER_WIDTH-1:0]   sel_user_s;
   logic [TD_IN-1:0]        sel_dest_s;
   logic                    out_ready_s;
   logic                    accept_s;

   // Bitmask bits for other egress ports do not matter here. They are only
   // folded into this sink.
   logic                    unused_tdest_s;
   assign unused_tdest_s = ^s_tdest;

   // Request vector: a source is valid and addresses this egress bitmask bit
   always_comb begin
      req_s = {NUM_INPUTS{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
         req_s[i] = s_tvalid[i] & s_tdest[i*TD_IN + PORT_INDEX];
      end
   end

   // Round-robin pick: first requester strictly after last_grant, wrapping
   always_comb begin
      arb_found_s = 1'b0;
      arb_pick_s  = last_grant_r;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         if (!arb_found_s && req_s[(int'(last_grant_r) + k) % NUM_INPUTS]) begin
            arb_found_s = 1'b1;
            arb_pick_s  = GW'((int'(last_grant_r) + k) % NUM_INPUTS);
         end else begin
            arb_found_s = arb_found_s;
         end
      end
   end

   // Select the granted source's fields
   always_comb begin
      sel_valid_s = s_tvalid[grant_r];
      sel_last_s  = s_tlast[grant_r];
      sel_data_s  = s_tdata[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
      sel_keep_s  = s_tkeep[int'(grant_r)*KEEP_WIDTH +: KEEP_WIDTH];
      sel_user_s  = s_tuser[int'(grant_r)*USER_WIDTH +: USER_WIDTH];
      sel_dest_s  = s_tdest[int'(grant_r)*TD_IN +: TD_IN];
   end

   // The output stage can take a beat when it is empty or is draining this cycle
   assign out_ready_s = !m_tvalid || m_tready;
   assign accept_s    = (state_r == ST_BUSY) && sel_valid_s && out_ready_s;

   // Per-source ready: only the granted source, and only while BUSY
   always_comb begin
      s_tready = {NUM_INPUTS{1'b0}};
      if (state_r == ST_BUSY) begin
         s_tready[grant_r] = out_ready_s;
      end else begin
         s_tready = {NUM_INPUTS{1'b0}};
      end
   end

   // Next-state logic: grant from IDLE, release on the accepted tlast beat
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arb_found_s) begin
               state_nxt_s = ST_BUSY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (accept_s && sel_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state, current grant and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         grant_r      <= {GW{1'b0}};
         last_grant_r <= GW'(NUM_INPUTS - 1);
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_IDLE && arb_found_s) begin
            grant_r <= arb_pick_s;
         end
         if (accept_s && sel_last_s) begin
            last_grant_r <= grant_r;
         end
      end
   end

   // Registered output stage: load on accept, hold under backpressure
   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= {DATA_WIDTH{1'b0}};
         m_tkeep  <= {KEEP_WIDTH{1'b0}};
         m_tlast  <= 1'b0;
         m_tuser  <= {USER_WIDTH{1'b0}};
         m_tdest  <= 7'd0;
      end else if (accept_s) begin
         m_tvalid <= 1'b1;
         m_tdata  <= sel_data_s;
         m_tkeep  <= sel_keep_s;
         m_tlast  <= sel_last_s;
         m_tuser  <= sel_user_s;
         m_tdest  <= sel_dest_s[10:4];
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

`ifdef CROSSBAR_EGRESS_PERF_EN
   logic multi_req_s;

   // More than one bit set means clearing the lowest set bit leaves a nonzero value
   assign multi_req_s =
      ((req_s & (req_s - {{(NUM_INPUTS-1){1'b0}}, 1'b1})) != {NUM_INPUTS{1'b0}});

   // Packet and contention counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_pkt_count        <= 32'd0;
         perf_contention_count <= 32'd0;
      end else begin
         if (accept_s && sel_last_s) begin
            perf_pkt_count <= perf_pkt_count + 32'd1;
         end
         if (state_r == ST_IDLE && arb_found_s && multi_req_s) begin
            perf_contention_count <= perf_contention_count + 32'd1;
         end
      end
   end
`endif

endmodule
